// File: rtl/top_logic.sv
// top_logic: registered a?b:c selector with sticky coverage of sampled (a,b,c) combinations.
module top_logic #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic       z,
  output logic [7:0] seen,
  output logic       all_seen
);
  logic       f;
  logic [7:0] seen_q, seen_d;
  assign f = a ? b : c;
  assign seen_d = seen_q | (8'd1 << {a, b, c});
  always_ff @(posedge clk or posedge rst) begin
    if (rst) seen_q <= 8'h00;
    else     seen_q <= seen_d;
  end
  assign seen = seen_q;
  assign all_seen = &seen_q;
  generate
    if (REG_OUT) begin : g_reg
      logic z_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) z_q <= 1'b0;
        else     z_q <= f;
      end
      assign z = z_q;
    end else begin : g_comb
      assign z = f;
    end
  endgenerate
endmodule

// File: tb/tb_top_logic.sv
// tb_top_logic: directed and random checks of both z variants against a truth-table model.
module tb_top_logic;
  logic       clk = 1'b0, rst = 1'b0, a = 1'b0, b = 1'b0, c = 1'b0;
  logic       z1, z0, all1, all0;
  logic [7:0] seen1, seen0;
  int         n_checks = 0, n_fails = 0;
  bit         tt [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  bit         m_z = 1'b0;
  logic [7:0] m_seen = 8'h00;
  top_logic #(.REG_OUT(1'b1)) dut (.clk(clk), .rst(rst), .a(a), .b(b), .c(c),
    .z(z1), .seen(seen1), .all_seen(all1));
  top_logic #(.REG_OUT(1'b0)) dut0 (.clk(clk), .rst(rst), .a(a), .b(b), .c(c),
    .z(z0), .seen(seen0), .all_seen(all0));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    logic [2:0] v;
    v = {a, b, c};
    chk({tag, "_z"}, {7'd0, z1}, {7'd0, m_z});
    chk({tag, "_seen"}, seen1, m_seen);
    chk({tag, "_all"}, {7'd0, all1}, {7'd0, m_seen == 8'hFF});
    chk({tag, "_z0"}, {7'd0, z0}, {7'd0, tt[v]});
    chk({tag, "_seen0"}, seen0, m_seen);
  endtask
  task automatic step(input logic [2:0] v, input string tag);
    {a, b, c} = v;
    @(posedge clk);
    if (!rst) begin
      m_z = tt[v];
      m_seen[v] = 1'b1;
    end
    #1;
    check_all(tag);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    m_z = 1'b0;
    m_seen = 8'h00;
    for (int i = 0; i < 3; i++) begin
      {a, b, c} = 3'($urandom);
      #1;
      check_all("reset_async");
      @(posedge clk);
      #1;
      check_all("reset_edge");
    end
    rst = 1'b0;
  endtask
  initial begin
    #1;
    do_reset();
    for (int i = 0; i < 8; i++) step(3'(i), "truth");
    chk("truth_seen_ff", seen1, 8'hFF);
    chk("truth_all", {7'd0, all1}, 8'h01);
    do_reset();
    step(3'b000, "part");
    step(3'b011, "part");
    step(3'b101, "part");
    chk("part_seen", seen1, 8'b0010_1001);
    chk("part_all", {7'd0, all1}, 8'h00);
    do_reset();
    for (int i = 0; i < 10; i++) step(3'b110, "hold");
    chk("hold_seen", seen1, 8'h40);
    chk("hold_z", {7'd0, z1}, 8'h01);
    step(3'b001, "sticky");
    chk("sticky_seen", seen1, 8'h42);
    chk("sticky_z", {7'd0, z1}, 8'h01);
    for (int i = 0; i < 8; i++) step(3'(i), "fill");
    chk("fill_all", {7'd0, all1}, 8'h01);
    rst = 1'b1;
    #1;
    m_z = 1'b0;
    m_seen = 8'h00;
    chk("midrst_seen", seen1, 8'h00);
    chk("midrst_all", {7'd0, all1}, 8'h00);
    chk("midrst_z", {7'd0, z1}, 8'h00);
    rst = 1'b0;
    step(3'b100, "after_rst");
    chk("after_rst_seen", seen1, 8'h10);
    {a, b, c} = 3'b010;
    #1;
    chk("comb_z_010", {7'd0, z0}, 8'h00);
    {a, b, c} = 3'b110;
    #1;
    chk("comb_z_110", {7'd0, z0}, 8'h01);
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      step(3'($urandom), "rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
